// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_pkg
//  Description : Shared types and the mode table for the video timing
//                generator. mode_t carries the raw CEA/VESA timing fields of
//                one mode. timing_t carries the derived counter boundaries
//                that the counter logic compares against.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

  localparam int MAX_MODES = 4;

  typedef struct packed {
    logic [11:0] ha;
    logic [11:0] hfp;
    logic [11:0] hs;
    logic [11:0] hbp;
    logic [10:0] va;
    logic [10:0] vfp;
    logic [10:0] vs;
    logic [10:0] vbp;
    logic        pos_pol;
  } mode_t;

  typedef mode_t [MAX_MODES-1:0] mode_table_t;

  // Derived boundaries. *_ss/*_se are sync start/end (end exclusive).
  // *_last is the final count value (HT-1 / VT-1).
  typedef struct packed {
    logic [11:0] h_act;
    logic [11:0] h_ss;
    logic [11:0] h_se;
    logic [11:0] h_last;
    logic [10:0] v_act;
    logic [10:0] v_ss;
    logic [10:0] v_se;
    logic [10:0] v_last;
    logic        pos_pol;
  } timing_t;

  localparam int TIMING_W = $bits(timing_t);

  localparam logic [1:0] MODE_640X480   = 2'd0;
  localparam logic [1:0] MODE_1280X720  = 2'd1;
  localparam logic [1:0] MODE_1920X1080 = 2'd2;
  localparam logic [1:0] MODE_800X600   = 2'd3;

  localparam mode_t MODE_0_CFG = '{12'd640,  12'd16,  12'd96,  12'd48,
                                   11'd480,  11'd10,  11'd2,   11'd33, 1'b0};
  localparam mode_t MODE_1_CFG = '{12'd1280, 12'd110, 12'd40,  12'd220,
                                   11'd720,  11'd5,   11'd5,   11'd20, 1'b1};
  localparam mode_t MODE_2_CFG = '{12'd1920, 12'd88,  12'd44,  12'd148,
                                   11'd1080, 11'd4,   11'd5,   11'd36, 1'b1};
  localparam mode_t MODE_3_CFG = '{12'd800,  12'd40,  12'd128, 12'd88,
                                   11'd600,  11'd1,   11'd4,   11'd23, 1'b1};

  // Element [0] is the rightmost operand of the concatenation.
  localparam mode_table_t MODE_TABLE = {MODE_3_CFG, MODE_2_CFG, MODE_1_CFG, MODE_0_CFG};

endpackage
`default_nettype wire

// File: rtl/video_timing_gen_mode_rom.sv
`default_nettype none
// ============================================================================
//  Module      : video_mode_rom
//  Description : Combinational mode-index to timing lookup. Converts the raw
//                porch/sync widths of the selected table entry into absolute
//                counter boundaries.
//  Ports       : idx_i    - mode index
//                timing_o - packed timing_t of the selected mode
//  Revision    : 1.0 - initial release
// ============================================================================
module video_mode_rom
  import video_timing_pkg::*;
#(
  parameter mode_table_t MODES = MODE_TABLE
) (
  input  logic [1:0]          idx_i,
  output logic [TIMING_W-1:0] timing_o
);

  mode_t   mode_w;
  timing_t timing_w;

  always_comb begin
    mode_w           = MODES[idx_i];
    timing_w         = '0;
    timing_w.h_act   = mode_w.ha;
    timing_w.h_ss    = mode_w.ha + mode_w.hfp;
    timing_w.h_se    = timing_w.h_ss + mode_w.hs;
    timing_w.h_last  = timing_w.h_se + mode_w.hbp - 12'd1;
    timing_w.v_act   = mode_w.va;
    timing_w.v_ss    = mode_w.va + mode_w.vfp;
    timing_w.v_se    = timing_w.v_ss + mode_w.vs;
    timing_w.v_last  = timing_w.v_se + mode_w.vbp - 11'd1;
    timing_w.pos_pol = mode_w.pos_pol;
  end

  assign timing_o = timing_w;

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen
//  Description : Runtime-selectable video timing generator. Counts h/v in
//                the order active, front porch, sync, back porch and emits
//                registered hsync/vsync/de/x/y/frame_start. Mode changes are
//                applied only at the last pixel of a frame.
//  Ports       : clk_pix      - pixel clock
//                rst          - synchronous active-high reset
//                mode_sel     - requested mode index (sampled every cycle)
//                hsync/vsync  - syncs with mode polarity applied
//                de, x, y     - active-video enable and pixel coordinates
//                frame_start  - one-cycle pulse on pixel (0,0)
//                mode_active  - mode currently driving timing
//                mode_pending - a valid change waits for the frame end
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int          XW           = 12,
  parameter int          YW           = 11,
  parameter int          NUM_MODES    = 4,
  parameter int          DEFAULT_MODE = 1,
  parameter mode_table_t MODES        = MODE_TABLE
) (
  input  logic          clk_pix,
  input  logic          rst,
  input  logic [1:0]    mode_sel,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          frame_start,
  output logic [1:0]    mode_active,
  output logic          mode_pending
);

  localparam logic [1:0] DEF_IDX = 2'(DEFAULT_MODE);
  localparam logic       DEF_POL = MODES[DEFAULT_MODE].pos_pol;

  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;
  logic [1:0]    mode_active_q, mode_active_d;
  timing_t       cfg_q;
  timing_t       rom_w;
  logic          sel_valid_w, line_end_w, frame_end_w;
  logic          de_c, hs_c, vs_c, fs_c;
  logic          hsync_q, vsync_q, de_q, fs_q, pending_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  // cfg_q always holds the decoded boundaries of mode_active_q: both are
  // loaded on the same edge from the same next-mode value.
  video_mode_rom #(
    .MODES (MODES)
  ) u_mode_rom (
    .idx_i    (mode_active_d),
    .timing_o (rom_w)
  );

  assign sel_valid_w = ({1'b0, mode_sel} < 3'(NUM_MODES));
  assign line_end_w  = (h_q == XW'(cfg_q.h_last));
  assign frame_end_w = line_end_w && (v_q == YW'(cfg_q.v_last));

  always_comb begin
    h_d           = h_q + XW'(1);
    v_d           = v_q;
    mode_active_d = mode_active_q;
    if (line_end_w) begin
      h_d = '0;
      v_d = v_q + YW'(1);
    end
    if (frame_end_w) begin
      v_d = '0;
      if (sel_valid_w) begin
        mode_active_d = mode_sel;
      end
    end
    // Reset must steer the ROM so cfg_q reloads the default mode.
    if (rst) begin
      h_d           = '0;
      v_d           = '0;
      mode_active_d = DEF_IDX;
    end
  end

  // vsync spans from (line v_ss, pixel h_ss) up to (line v_se, pixel h_ss),
  // so both edges line up with the hsync leading edge.
  always_comb begin
    de_c = (h_q < XW'(cfg_q.h_act)) && (v_q < YW'(cfg_q.v_act));
    hs_c = (h_q >= XW'(cfg_q.h_ss)) && (h_q < XW'(cfg_q.h_se));
    vs_c = ((v_q == YW'(cfg_q.v_ss)) && (h_q >= XW'(cfg_q.h_ss))) ||
           ((v_q >  YW'(cfg_q.v_ss)) && (v_q < YW'(cfg_q.v_se)))  ||
           ((v_q == YW'(cfg_q.v_se)) && (h_q < XW'(cfg_q.h_ss)));
    fs_c = (h_q == '0) && (v_q == '0);
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      mode_active_q <= DEF_IDX;
      cfg_q         <= rom_w;
      hsync_q       <= ~DEF_POL;
      vsync_q       <= ~DEF_POL;
      de_q          <= 1'b0;
      fs_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      pending_q     <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      mode_active_q <= mode_active_d;
      cfg_q         <= rom_w;
      hsync_q       <= hs_c ~^ cfg_q.pos_pol;
      vsync_q       <= vs_c ~^ cfg_q.pos_pol;
      de_q          <= de_c;
      fs_q          <= fs_c;
      x_q           <= h_q;
      y_q           <= v_q;
      // Compared against the next mode so a request consumed at the frame
      // boundary does not leave a stale pending cycle behind.
      pending_q     <= sel_valid_w && (mode_sel != mode_active_d);
    end
  end

  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign de           = de_q;
  assign x            = x_q;
  assign y            = y_q;
  assign frame_start  = fs_q;
  assign mode_active  = mode_active_q;
  assign mode_pending = pending_q;

endmodule
`default_nettype wire
